rx_link_ctrl: RTL and testbench

Link-sync controller for the 8b/10b serial receive path. It consumes per-code-group strobes and flags from the receive decoder (comma seen, invalid code-group, running-disparity error) and sequences the link through comma search, lock acquisition and loss-of-sync with error hysteresis. It gates decoded data toward the VGA sink, enables or freezes word-boundary alignment in the receiver, requests a comma burst from the transmit side when the link is down, and keeps a saturating error counter.

---
 rtl/rx_link_pkg.sv | 25 ++
 rtl/rx_link_ctrl_err_hyst.sv | 66 ++++++
 rtl/rx_link_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rx_link_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_link_pkg.sv
// Shared definitions for the 8b/10b receive link-sync controller:
// FSM state encoding, K28.5 comma code-groups and default thresholds.
package rx_link_pkg;

  typedef enum logic [1:0] {
    ST_LOS       = 2'd0,
    ST_COMMA_DET = 2'd1,
    ST_SYNC      = 2'd2
  } link_state_e;

  // K28.5 in both running disparities (bit order abcdei fghj).
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;

  localparam int unsigned DEF_COMMAS_TO_LOCK = 3;
  localparam int unsigned DEF_ERRS_TO_LOSE   = 4;
  localparam int unsigned DEF_GOOD_TO_CLEAR  = 4;
  localparam int unsigned DEF_ERR_CNT_W      = 16;

  // True when a raw 10b code-group is a K28.5 comma of either disparity.
  function automatic logic is_k28_5(input logic [9:0] code);
    return (code == K28_5_RDP) || (code == K28_5_RDN);
  endfunction

endpackage

// File: rtl/rx_link_ctrl_err_hyst.sv
// Error hysteresis for the SYNC state: an error level that rises by one per
// errored code-group and falls by one after a run of good code-groups.
// loss_o is combinational and flags the strobe that pushes the level to the
// loss threshold, so the FSM can leave SYNC on that same edge.
module err_hyst
  import rx_link_pkg::*;
#(
  parameter int unsigned ERRS_TO_LOSE  = DEF_ERRS_TO_LOSE,
  parameter int unsigned GOOD_TO_CLEAR = DEF_GOOD_TO_CLEAR
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,   // held while not in SYNC: level starts at 0 on entry
  input  logic err_i,   // qualified errored code-group
  input  logic good_i,  // qualified good code-group (comma or data)
  output logic loss_o
);

  localparam logic [3:0] LOSE_LVL = 4'(ERRS_TO_LOSE);
  localparam logic [7:0] CLR_RUN  = 8'(GOOD_TO_CLEAR);

  logic [3:0] level_q, level_d, level_inc;
  logic [7:0] good_q, good_d, good_inc;

  // Next error level / good-run count and the loss-of-sync decision.
  always_comb begin
    level_d   = level_q;
    good_d    = good_q;
    loss_o    = 1'b0;
    level_inc = level_q + 4'd1;
    good_inc  = good_q + 8'd1;
    if (clr_i) begin
      level_d = '0;
      good_d  = '0;
    end else if (err_i) begin
      good_d = '0;
      if (level_inc == LOSE_LVL) begin
        loss_o  = 1'b1;
        level_d = '0;
      end else begin
        level_d = level_inc;
      end
    end else if (good_i) begin
      if (level_q == '0) begin
        good_d = '0;
      end else if (good_inc == CLR_RUN) begin
        level_d = level_q - 4'd1;
        good_d  = '0;
      end else begin
        good_d = good_inc;
      end
    end
  end

  // Hysteresis state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
      good_q  <= '0;
    end else begin
      level_q <= level_d;
      good_q  <= good_d;
    end
  end

endmodule

// File: rtl/rx_link_ctrl.sv
// Link-sync controller for the 8b/10b receive path: comma search, lock,
// loss-of-sync with hysteresis, data gating and a saturating error counter.
// Optional build macro LINK_TIMEOUT_EN adds a watchdog that forces LOS and
// pulses realignReq low for one cycle when lock is not reached in time.
module rx_link_ctrl
  import rx_link_pkg::*;
#(
  parameter int unsigned COMMAS_TO_LOCK = DEF_COMMAS_TO_LOCK,
  parameter int unsigned ERRS_TO_LOSE   = DEF_ERRS_TO_LOSE,
  parameter int unsigned GOOD_TO_CLEAR  = DEF_GOOD_TO_CLEAR,
  parameter int unsigned ERR_CNT_W      = DEF_ERR_CNT_W
`ifdef LINK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC  = 4096
`endif
) (
  input  logic                 clkRX,
  input  logic                 reset,
  input  logic                 symStb,
  input  logic                 isComma,
  input  logic                 invalidData,
  input  logic                 wrongRD,
  input  logic                 clrErr,
  output logic                 syncOk,
  output logic                 alignEn,
  output logic                 dataEn,
  output logic                 realignReq,
  output logic [ERR_CNT_W-1:0] errCount,
  output logic [1:0]           state
);

  localparam logic [3:0] LOCK_N        = 4'(COMMAS_TO_LOCK);
  localparam bit         LOCK_ON_FIRST = (COMMAS_TO_LOCK == 1);

  link_state_e          state_q, state_d;
  logic [3:0]           comma_cnt_q, comma_cnt_d, comma_inc;
  logic                 data_en_q, data_en_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sym_err, sym_good, sym_comma;
  logic                 loss, timeout;

  // An errored comma counts only as an error.
  assign sym_err   = symStb & (invalidData | wrongRD);
  assign sym_good  = symStb & ~(invalidData | wrongRD);
  assign sym_comma = sym_good & isComma;

  err_hyst #(
    .ERRS_TO_LOSE (ERRS_TO_LOSE),
    .GOOD_TO_CLEAR(GOOD_TO_CLEAR)
  ) u_err_hyst (
    .clk_i (clkRX),
    .rst_i (reset),
    .clr_i (state_q != ST_SYNC),
    .err_i (sym_err),
    .good_i(sym_good),
    .loss_o(loss)
  );

`ifdef LINK_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            rereq_q, rereq_d;

  assign timeout = (state_q != ST_SYNC) && (wdog_q == WD_LAST);

  // Watchdog: count cycles outside SYNC, restart on timeout or while locked.
  always_comb begin
    wdog_d  = wdog_q + 1'b1;
    rereq_d = timeout;
    if ((state_q == ST_SYNC) || timeout) begin
      wdog_d = '0;
    end
  end

  // Watchdog registers; rereq_q marks the cycle realignReq is dropped.
  always_ff @(posedge clkRX or posedge reset) begin
    if (reset) begin
      wdog_q  <= '0;
      rereq_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      rereq_q <= rereq_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Link FSM next state, comma counter and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    comma_inc   = comma_cnt_q + 4'd1;
    syncOk      = 1'b0;
    alignEn     = 1'b0;
    realignReq  = 1'b1;
    case (state_q)
      ST_LOS: begin
        alignEn = 1'b1;
        if (sym_comma) begin
          comma_cnt_d = 4'd1;
          state_d     = LOCK_ON_FIRST ? ST_SYNC : ST_COMMA_DET;
        end
      end
      ST_COMMA_DET: begin
        if (sym_err) begin
          state_d     = ST_LOS;
          comma_cnt_d = '0;
        end else if (sym_comma) begin
          comma_cnt_d = comma_inc;
          if (comma_inc == LOCK_N) begin
            state_d = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        syncOk     = 1'b1;
        realignReq = 1'b0;
        if (loss) begin
          state_d     = ST_LOS;
          comma_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_LOS;
        comma_cnt_d = '0;
      end
    endcase
    if (timeout) begin
      state_d     = ST_LOS;
      comma_cnt_d = '0;
    end
`ifdef LINK_TIMEOUT_EN
    if (rereq_q) begin
      realignReq = 1'b0;
    end
`endif
  end

  // Data gating and saturating error count; clrErr beats a same-cycle error.
  always_comb begin
    data_en_d = (state_q == ST_SYNC) & sym_good & ~isComma;
    err_cnt_d = err_cnt_q;
    if (clrErr) begin
      err_cnt_d = '0;
    end else if ((state_q == ST_SYNC) && sym_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Controller state registers.
  always_ff @(posedge clkRX or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOS;
      comma_cnt_q <= '0;
      data_en_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      data_en_q   <= data_en_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign state    = state_q;
  assign dataEn   = data_en_q;
  assign errCount = err_cnt_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Self-checking bench for rx_link_ctrl: directed scenarios plus randomized
// strobes, all compared against a cycle-level behavioural model.
// Build with LINK_TIMEOUT_EN defined to cover the watchdog.
module tb_rx_link_ctrl;

  localparam int LOCK  = 3;
  localparam int LOSE  = 4;
  localparam int GCLR  = 4;
  localparam int ECW   = 4;
  localparam int ECMAX = 15;
`ifdef LINK_TIMEOUT_EN
  localparam int TOUT  = 64;
`endif
  localparam logic [9:0] RST_VEC = {2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0, comma = 1'b0, inv = 1'b0, wrd = 1'b0, clr = 1'b0;
  logic sync_ok, align_en, data_en, realign_req;
  logic [ECW-1:0] err_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_link_ctrl #(
    .COMMAS_TO_LOCK(LOCK),
    .ERRS_TO_LOSE  (LOSE),
    .GOOD_TO_CLEAR (GCLR),
    .ERR_CNT_W     (ECW)
`ifdef LINK_TIMEOUT_EN
    , .TIMEOUT_CYC (TOUT)
`endif
  ) dut (
    .clkRX      (clk),
    .reset      (rst),
    .symStb     (stb),
    .isComma    (comma),
    .invalidData(inv),
    .wrongRD    (wrd),
    .clrErr     (clr),
    .syncOk     (sync_ok),
    .alignEn    (align_en),
    .dataEn     (data_en),
    .realignReq (realign_req),
    .errCount   (err_count),
    .state      (state)
  );

  // ---------------- behavioural reference model ----------------
  int m_state, m_ccnt, m_lvl, m_gc, m_ecnt, m_wd;
  bit m_den, m_rereq;

  function automatic void model_reset();
    m_state = 0; m_ccnt = 0; m_lvl = 0; m_gc = 0; m_ecnt = 0; m_wd = 0;
    m_den = 1'b0; m_rereq = 1'b0;
  endfunction

  function automatic void model_step(bit s, bit c, bit i, bit w, bit cl);
    bit e   = s && (i || w);
    bit g   = s && !e;
    bit cm  = g && c;
    bit tmo = 1'b0;
    int ns  = m_state;
`ifdef LINK_TIMEOUT_EN
    if (m_state != 2) begin
      if (m_wd + 1 == TOUT) begin tmo = 1'b1; m_wd = 0; end
      else m_wd = m_wd + 1;
    end else begin
      m_wd = 0;
    end
`endif
    m_den = (m_state == 2) && g && !c;
    if (cl) m_ecnt = 0;
    else if (m_state == 2 && e && m_ecnt < ECMAX) m_ecnt = m_ecnt + 1;
    case (m_state)
      0: if (cm) begin
           m_ccnt = 1; ns = (LOCK == 1) ? 2 : 1; m_lvl = 0; m_gc = 0;
         end
      1: if (e) begin
           ns = 0; m_ccnt = 0;
         end else if (cm) begin
           m_ccnt = m_ccnt + 1;
           if (m_ccnt == LOCK) begin ns = 2; m_lvl = 0; m_gc = 0; end
         end
      default: if (e) begin
           m_lvl = m_lvl + 1; m_gc = 0;
           if (m_lvl == LOSE) ns = 0;
         end else if (g) begin
           if (m_lvl > 0) begin
             m_gc = m_gc + 1;
             if (m_gc == GCLR) begin m_lvl = m_lvl - 1; m_gc = 0; end
           end else begin
             m_gc = 0;
           end
         end
    endcase
    if (tmo) begin ns = 0; m_ccnt = 0; end
    m_rereq = tmo;
    m_state = ns;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {2'(m_state), (m_state == 2), (m_state == 0),
            ((m_state != 2) && !m_rereq), m_den, 4'(m_ecnt)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {state, sync_ok, align_en, realign_req, data_en, err_count};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit s, input bit c, input bit i, input bit w, input bit cl);
    stb = s; comma = c; inv = i; wrd = w; clr = cl;
    @(posedge clk);
    model_step(s, c, i, w, cl);
    #1;
    stb = 1'b0; comma = 1'b0; inv = 1'b0; wrd = 1'b0; clr = 1'b0;
    if (s || cl)
      $display("t=%0t stb=%b comma=%b inv=%b wrd=%b clr=%b -> state=%0d sync=%b dataEn=%b errCount=%0d",
               $time, s, c, i, w, cl, state, sync_ok, data_en, err_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0; comma = 1'b0; inv = 1'b0; wrd = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic lock_link();
    for (int k = 0; k < LOCK; k++) tick(1, 1, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_values got %b want %b", dut_vec(), RST_VEC);
    end
    lock_link();
    for (int k = 0; k < LOSE; k++) tick(1, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_pre_comma_det got %b want %b", dut_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_async_mid got %b want %b", dut_vec(), RST_VEC);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_resume got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < LOCK; k++) begin
      tick(1, 1, 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_comma%0d got %b want %b", k, dut_vec(), exp_vec());
      end
      if (k == 0) begin
        checks++;
        if (state !== 2'd1 || align_en !== 1'b0) begin
          errors++; $display("FAIL lock_first_comma got state=%0d alignEn=%b want state=1 alignEn=0", state, align_en);
        end
      end
      if (k == LOCK - 1) begin
        checks++;
        if (state !== 2'd2 || sync_ok !== 1'b1) begin
          errors++; $display("FAIL lock_sync got state=%0d syncOk=%b want state=2 syncOk=1", state, sync_ok);
        end
      end else begin
        for (int j = 0; j < 9; j++) begin
          tick(0, 0, 0, 0, 0);
          checks++;
          if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL lock_idle%0d_%0d got %b want %b", k, j, dut_vec(), exp_vec());
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 1, 0);
    checks++;
    if (state !== 2'd0 || realign_req !== 1'b1 || align_en !== 1'b1) begin
      errors++; $display("FAIL abort_los got state=%0d realignReq=%b alignEn=%b want 0 1 1", state, realign_req, align_en);
    end
    tick(1, 1, 1, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL abort_err_comma got %b want %b", dut_vec(), exp_vec());
    end
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL abort_restart got state=%0d want 1", state);
    end
    tick(1, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || state !== 2'd2) begin
      errors++; $display("FAIL abort_relock got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_hyst();
    do_reset();
    lock_link();
    tick(1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd2 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL hyst_level3 got %b want %b", dut_vec(), exp_vec());
    end
    tick(1, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd0 || err_count !== 4'd4 || sync_ok !== 1'b0) begin
      errors++; $display("FAIL hyst_loss got state=%0d errCount=%0d want state=0 errCount=4", state, err_count);
    end
    do_reset();
    lock_link();
    tick(1, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) tick(1, (k == 2), 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 0);
    checks++;
    if (state !== 2'd2 || err_count !== 4'd4 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL hyst_recover got state=%0d errCount=%0d want state=2 errCount=4", state, err_count);
    end
  endtask

  task automatic test_gating();
    int pulses;
    bit exp_d;
    bit sc[5];
    bit si[5];
    bit ss[5];
    sc = '{0, 1, 0, 0, 0};
    si = '{0, 0, 0, 1, 0};
    ss = '{1, 1, 1, 1, 0};
    do_reset();
    tick(1, 0, 0, 0, 0);
    checks++;
    if (data_en !== 1'b0) begin
      errors++; $display("FAIL gating_los got dataEn=%b want 0", data_en);
    end
    lock_link();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick(ss[k], sc[k], si[k], 0, 0);
      exp_d = ss[k] && !sc[k] && !si[k];
      if (data_en === 1'b1) pulses++;
      checks++;
      if (data_en !== exp_d || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL gating_step%0d got dataEn=%b want %b", k, data_en, exp_d);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL gating_count got %0d pulses want 2", pulses);
    end
  endtask

  task automatic test_counter();
    int exp_c;
    do_reset();
    lock_link();
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 1, 0, 0);
      exp_c = (i + 1 > ECMAX) ? ECMAX : i + 1;
      checks++;
      if (err_count !== 4'(exp_c) || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL counter_err%0d got %0d want %0d", i, err_count, exp_c);
      end
      for (int k = 0; k < GCLR; k++) tick(1, 0, 0, 0, 0);
    end
    tick(1, 0, 0, 1, 1);
    checks++;
    if (err_count !== 4'd0 || state !== 2'd2) begin
      errors++; $display("FAIL counter_clr_wins got errCount=%0d state=%0d want 0 2", err_count, state);
    end
    tick(1, 0, 1, 0, 0);
    checks++;
    if (err_count !== 4'd1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL counter_after_clr got %0d want 1", err_count);
    end
  endtask

  task automatic test_timeout();
    bit exp_r;
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      tick(0, 0, 0, 0, 0);
`ifdef LINK_TIMEOUT_EN
      exp_r = (i != TOUT);
`else
      exp_r = 1'b1;
`endif
      checks++;
      if (realign_req !== exp_r || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_cyc%0d got realignReq=%b want %b", i, realign_req, exp_r);
      end
    end
  endtask

  task automatic test_random();
    bit s, c, i, w, cl;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      s  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 2) == 0);
      i  = ($urandom_range(0, 24) == 0);
      w  = ($urandom_range(0, 24) == 0);
      cl = ($urandom_range(0, 63) == 0);
      tick(s, c, i, w, cl);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d got %b want %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_abort();
    test_hyst();
    test_gating();
    test_counter();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached at t=%0t", $time);
    $fatal(1, "time limit");
  end

endmodule
